// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port synchronous data memory.
// Define DMEM_ARB_RR_EN for round-robin ties; default is fixed priority (port 0).
module dmem_arbiter #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_wr_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic        m0_err_o,
  output logic [31:0] m0_data_o,
  input  logic        m1_req_i,
  input  logic        m1_wr_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic        m1_err_o,
  output logic [31:0] m1_data_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic owner_q;
  logic owner_d;
  logic is_err_q;
  logic is_err_d;
  logic last_q;
  logic last_d;
  logic init_q;
  logic blk;

  logic [1:0]  req;
  logic [1:0]  wr;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] widx [2];
  logic [1:0]  bad;

  logic        tie_win;
  logic        win;

  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [1:0]  err;
  logic [31:0] rdata [2];

  assign req      = {m1_req_i, m0_req_i};
  assign wr       = {m1_wr_i, m0_wr_i};
  assign addr[0]  = m0_addr_i;
  assign addr[1]  = m1_addr_i;
  assign wdata[0] = m0_data_i;
  assign wdata[1] = m1_data_i;

  // Outputs are silenced during reset and the cycle following it.
  assign blk = rst_i | init_q;

  // Word index and legality (alignment and range) per port.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      widx[i] = {2'b00, addr[i][31:2]};
      bad[i]  = (addr[i][1:0] != 2'b00) || (widx[i] >= 32'(DEPTH));
    end
  end

  // Tie policy: alternate away from the last grant, or always port 0.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    tie_win = ~last_q;
`else
    tie_win = 1'b0;
`endif
  end

  // Winner selection among the requesting ports.
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      req[0] && req[1]:  win = tie_win;
      req[1] && !req[0]: win = 1'b1;
      default:           win = 1'b0;
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      is_err_q <= 1'b0;
      last_q   <= 1'b1;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      is_err_q <= is_err_d;
      last_q   <= last_d;
      init_q   <= 1'b0;
    end
  end

  // Next state, grants, memory strobes and response pulses.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    is_err_d   = is_err_q;
    last_d     = last_q;
    gnt        = 2'b00;
    rvalid     = 2'b00;
    err        = 2'b00;
    rdata[0]   = 32'h0;
    rdata[1]   = 32'h0;
    mem_rd_o   = 1'b0;
    mem_wr_o   = 1'b0;
    mem_addr_o = 32'h0;
    mem_data_o = 32'h0;
    if (!blk) begin
      unique case (state_q)
        IDLE: begin
          if (|req) begin
            gnt[win] = 1'b1;
            last_d   = win;
            if (bad[win]) begin
              state_d  = RESP;
              owner_d  = win;
              is_err_d = 1'b1;
            end else if (wr[win]) begin
              mem_wr_o   = 1'b1;
              mem_addr_o = widx[win];
              mem_data_o = wdata[win];
            end else begin
              mem_rd_o   = 1'b1;
              mem_addr_o = widx[win];
              state_d    = RESP;
              owner_d    = win;
              is_err_d   = 1'b0;
            end
          end
        end
        RESP: begin
          state_d = IDLE;
          if (is_err_q) begin
            err[owner_q] = 1'b1;
          end else begin
            rvalid[owner_q] = 1'b1;
            rdata[owner_q]  = mem_data_i;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign m0_gnt_o    = gnt[0];
  assign m1_gnt_o    = gnt[1];
  assign m0_rvalid_o = rvalid[0];
  assign m1_rvalid_o = rvalid[1];
  assign m0_err_o    = err[0];
  assign m1_err_o    = err[1];
  assign m0_data_o   = rdata[0];
  assign m1_data_o   = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model.
// Tie expectations follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  int          pass_cnt;
  int          total;

  dmem_arbiter #(.DEPTH(256)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .m0_req_i    (m0_req),
    .m0_wr_i     (m0_wr),
    .m0_addr_i   (m0_addr),
    .m0_data_i   (m0_wdata),
    .m0_gnt_o    (m0_gnt),
    .m0_rvalid_o (m0_rvalid),
    .m0_err_o    (m0_err),
    .m0_data_o   (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_wr_i     (m1_wr),
    .m1_addr_i   (m1_addr),
    .m1_data_i   (m1_wdata),
    .m1_gnt_o    (m1_gnt),
    .m1_rvalid_o (m1_rvalid),
    .m1_err_o    (m1_err),
    .m1_data_o   (m1_rdata),
    .mem_rd_o    (mem_rd),
    .mem_wr_o    (mem_wr),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_wdata),
    .mem_data_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    idle_in();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    logic [9:0] v;
    cyc();
    rst = 1'b1;
    m0_req = 1; m0_wr = 0; m0_addr = 32'h0;
    m1_req = 1; m1_wr = 0; m1_addr = 32'h4;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rst = 1'b0;
      @(negedge clk);
      v = {m0_gnt, m1_gnt, mem_rd, mem_wr, m0_rvalid, m1_rvalid,
           m0_err, m1_err, |m0_rdata, |m1_rdata};
      total++;
      if (v !== 10'h0)
        $display("FAIL reset_quiet c%0d: got %b want 0", c, v);
      else
        pass_cnt++;
      cyc();
    end
    idle_in();
  endtask

  task automatic test_write_read();
    m0_req = 1; m0_wr = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++;
    if ({m0_gnt, mem_wr, mem_rd, mem_addr, mem_wdata} !==
        {1'b1, 1'b1, 1'b0, 32'd4, 32'hDEADBEEF})
      $display("FAIL wr_grant: got g%b w%b r%b a%h d%h want g1 w1 r0 a4 dDEADBEEF",
               m0_gnt, mem_wr, mem_rd, mem_addr, mem_wdata);
    else pass_cnt++;
    cyc();
    m0_wr = 0; m0_wdata = 0;
    @(negedge clk);
    total++;
    if ({m0_gnt, mem_rd, mem_wr, mem_addr} !== {1'b1, 1'b1, 1'b0, 32'd4})
      $display("FAIL rd_grant: got g%b r%b w%b a%h want g1 r1 w0 a4",
               m0_gnt, mem_rd, mem_wr, mem_addr);
    else pass_cnt++;
    cyc();
    idle_in();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m0_data_o_chk(), m0_gnt} !== {1'b1, 32'hDEADBEEF, 1'b0})
      $display("FAIL rd_data: got v%b d%h g%b want v1 dDEADBEEF g0",
               m0_rvalid, m0_rdata, m0_gnt);
    else pass_cnt++;
    cyc();
  endtask

  function automatic logic [31:0] m0_data_o_chk();
    return m0_rdata;
  endfunction

  task automatic test_arbitration();
    logic [1:0] eg [6];
    logic [1:0] ev [6];
`ifdef DMEM_ARB_RR_EN
    eg = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    ev = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
`else
    eg = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    ev = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`endif
    do_reset();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h10;
    m1_req = 1; m1_wr = 0; m1_addr = 32'h10;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({m1_gnt, m0_gnt, m1_rvalid, m0_rvalid} !== {eg[c], ev[c]})
        $display("FAIL arb c%0d: got gnt%b rv%b want gnt%b rv%b",
                 c, {m1_gnt, m0_gnt}, {m1_rvalid, m0_rvalid}, eg[c], ev[c]);
      else pass_cnt++;
      cyc();
    end
    idle_in();
  endtask

  task automatic test_errors();
    m1_req = 1; m1_wr = 0; m1_addr = 32'h11;
    @(negedge clk);
    total++;
    if ({m1_gnt, mem_rd, mem_wr} !== 3'b100)
      $display("FAIL misalign_gnt: got g%b r%b w%b want g1 r0 w0",
               m1_gnt, mem_rd, mem_wr);
    else pass_cnt++;
    cyc();
    idle_in();
    @(negedge clk);
    total++;
    if ({m1_err, m1_rvalid, m1_rdata, m0_err} !== {1'b1, 1'b0, 32'h0, 1'b0})
      $display("FAIL misalign_err: got e%b v%b d%h e0%b want e1 v0 d0 e0_0",
               m1_err, m1_rvalid, m1_rdata, m0_err);
    else pass_cnt++;
    cyc();
    m1_req = 1; m1_wr = 1; m1_addr = 32'h400; m1_wdata = 32'h12345678;
    @(negedge clk);
    total++;
    if ({m1_gnt, mem_wr, mem_rd} !== 3'b100)
      $display("FAIL range_gnt: got g%b w%b r%b want g1 w0 r0",
               m1_gnt, mem_wr, mem_rd);
    else pass_cnt++;
    cyc();
    idle_in();
    @(negedge clk);
    total++;
    if ({m1_err, m1_rvalid, mem_wr} !== 3'b100)
      $display("FAIL range_err: got e%b v%b w%b want e1 v0 w0",
               m1_err, m1_rvalid, mem_wr);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [3];
    wd = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    for (int c = 0; c < 3; c++) begin
      m0_req = 1; m0_wr = 1; m0_addr = 32'(4 * c); m0_wdata = wd[c];
      @(negedge clk);
      total++;
      if ({m0_gnt, mem_wr, mem_addr, mem_wdata} !== {2'b11, 32'(c), wd[c]})
        $display("FAIL b2b_wr%0d: got g%b w%b a%h d%h want g1 w1 a%h d%h",
                 c, m0_gnt, mem_wr, mem_addr, mem_wdata, c, wd[c]);
      else pass_cnt++;
      cyc();
    end
    m0_wr = 0; m0_wdata = 0; m0_addr = 32'h4;
    @(negedge clk);
    cyc();
    idle_in();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, wd[1]})
      $display("FAIL b2b_rd4: got v%b d%h want v1 d%h", m0_rvalid, m0_rdata, wd[1]);
    else pass_cnt++;
    cyc();
    m0_req = 1; m0_addr = 32'h8;
    @(negedge clk);
    cyc();
    idle_in();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m0_rdata, m1_rdata} !== {1'b1, wd[2], 32'h0})
      $display("FAIL b2b_rd8: got v%b d%h d1%h want v1 d%h d1 0",
               m0_rvalid, m0_rdata, m1_rdata, wd[2]);
    else pass_cnt++;
    cyc();
  endtask

  task automatic test_reset_in_resp();
    m0_req = 1; m0_wr = 0; m0_addr = 32'h0;
    @(negedge clk);
    total++;
    if ({m0_gnt, mem_rd} !== 2'b11)
      $display("FAIL rr_gnt: got g%b r%b want g1 r1", m0_gnt, mem_rd);
    else pass_cnt++;
    cyc();
    rst = 1'b1;
    idle_in();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m0_err, m0_rdata} !== 34'h0)
      $display("FAIL rr_drop: got v%b e%b d%h want 0", m0_rvalid, m0_err, m0_rdata);
    else pass_cnt++;
    cyc();
    rst = 1'b0;
    m0_req = 1; m0_wr = 0; m0_addr = 32'h8;
    @(negedge clk);
    total++;
    if ({m0_gnt, m0_rvalid, mem_rd} !== 3'b000)
      $display("FAIL rr_post: got g%b v%b r%b want 0", m0_gnt, m0_rvalid, mem_rd);
    else pass_cnt++;
    cyc();
    @(negedge clk);
    total++;
    if ({m0_gnt, mem_rd} !== 2'b11)
      $display("FAIL rr_idle: got g%b r%b want g1 r1", m0_gnt, mem_rd);
    else pass_cnt++;
    cyc();
    idle_in();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hC0C0_0003})
      $display("FAIL rr_data: got v%b d%h want v1 dC0C00003", m0_rvalid, m0_rdata);
    else pass_cnt++;
    cyc();
  endtask

  initial begin
    pass_cnt = 0;
    total    = 0;
    rst      = 1'b1;
    idle_in();
    test_reset();
    test_write_read();
    test_arbitration();
    test_errors();
    test_back_to_back();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
